fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that drives the word-indexed PC of the combinational `instruction_mem` and delivers fetched words to the decode stage through a valid/ready handshake. It owns the program counter, a 2-entry fetch buffer, branch/jump redirects with flush, and a start/halt state machine. It sits between `instruction_mem` (PC in, dataout back, same cycle) and the decoder.

## Interface
- `RESET_PC`, 0: word address loaded into PC on reset and on `start`.
- `MEM_WORDS`, 256: instruction memory depth; a PC at or above this value is a fault.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  1-cycle pulse; IDLE/HALT -> RUN, PC <= `RESET_PC`.
- `halt_req`  in  1  level; stop issuing fetches, drain the buffer, go to HALT.
- `redirect`  in  1  1-cycle pulse; flush the buffer, PC <= `redirect_pc`.
- `redirect_pc`  in  32  target word address.
- `mem_pc`  out  32  address to `instruction_mem` PC.
- `mem_data`  in  32  `instruction_mem` dataout, valid in the same cycle.
- `instr_valid`  out  1  buffer head valid.
- `instr_ready`  in  1  decoder accepts the head.
- `instr`  out  32  head instruction word.
- `instr_pc`  out  32  word address of the head.
- `fault`  out  1  sticky; set when a fetch targets PC >= `MEM_WORDS`.
- `busy`  out  1  high in RUN and DRAIN.

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - DRAIN
  - HALT
- Transitions:
  - IDLE/HALT --`start`--> RUN. `start` also clears `fault`.
  - RUN --`halt_req` or fault--> DRAIN.
  - DRAIN --buffer empty--> HALT.
  - `start` in RUN or DRAIN is ignored.
- Fetch: in RUN, a fetch fires when the buffer is not full, or is full and a dequeue happens this cycle. On a fetch:
  - push {`mem_data`, `mem_pc`};
  - PC <= PC+1 (mod 2^32).
- `mem_pc` = PC at all times. It is combinational from the register, so no extra logic sits in the memory path.
- Buffer: 2-entry FIFO, in-order.
  - Dequeue when `instr_valid && instr_ready`.
  - Simultaneous push and pop keeps the occupancy unchanged.
- Redirect: takes priority over fetch and dequeue in the same cycle.
  - Buffer emptied and PC <= `redirect_pc`.
  - No fetch that cycle; `instr_valid` is 0 the next cycle.
  - Honoured in RUN and DRAIN. In DRAIN it empties the buffer, so the block reaches HALT next cycle. Ignored in IDLE/HALT.
- Fault:
  - Condition: RUN and PC >= `MEM_WORDS` at a would-be fetch.
  - Effect: no push; `fault` <= 1; state -> DRAIN.
  - Already-buffered words still drain normally.
- `halt_req` together with `redirect`: the redirect applies (flush, PC loaded), then the block enters DRAIN.

## Timing
- Reset values:
  - state IDLE, PC = `RESET_PC`;
  - buffer empty: `instr_valid` 0, `instr` 0, `instr_pc` 0;
  - `fault` 0, `busy` 0.
- `rst_n` low mid-run: the buffer is cleared immediately, asynchronously.
- Latency:
  - `start` at edge N -> RUN and first fetch in cycle N+1 -> `instr_valid` high after edge N+2 with `instr_pc` = `RESET_PC`.
  - `redirect` -> first word from the new target is valid 2 edges later.
- Throughput: 1 instruction/cycle sustained while `instr_ready` is held high.
- With `instr_ready` low, the buffer fills in 2 cycles and fetch stops. `instr`/`instr_pc` stay stable while valid and not accepted.
- `busy` drops on the edge that enters HALT.

## Structure
- Shared package `fetch_pkg`:
  - state encoding (IDLE=0, RUN=1, DRAIN=2, HALT=3);
  - `WORD_W`=32;
  - buffer depth constant 2.
- One sub-module, `fetch_fifo`:
  - 2-deep, width 64 ({pc, instr});
  - ports: push, pop, flush, full, empty, head.
- The top level holds the FSM, the PC register, fault logic and the fetch-fire equation.

## Test plan
- Reset, then `start` with `RESET_PC`=0 and `instr_ready`=1 -> `instr_pc` 0,1,2,3 on consecutive cycles, `instr` = memword[0..3].
- `instr_ready` held 0 for 5 cycles after the first valid -> buffer holds pc 0,1; PC stops at 2; on release, pc 0,1,2 stream with no gap or duplicate.
- `redirect` to 0x20 in the same cycle as a dequeue of pc 5 -> pc 5 and the next word are discarded; the next `instr_pc` is 0x20, 2 edges later.
- `MEM_WORDS`=8, run from 0 -> words 0..7 delivered, `fault`=1 when PC=8, then HALT, `busy`=0; `start` clears `fault` and refetches from 0.
- `halt_req` while 2 entries are buffered -> no new fetch; both entries drain under ready, then HALT.
- `rst_n` asserted low between clock edges with the buffer full -> `instr_valid`=0 and PC=`RESET_PC` immediately, state IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and widths for the fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_e;
  localparam int WORD_W  = 32;
  localparam int DEPTH   = 2;
  localparam int ENTRY_W = 2 * WORD_W;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry in-order buffer of {pc, instr} with flush
module fetch_fifo import fetch_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);
  logic [1:0] cnt_q, cnt_d, cnt_p;
  logic [ENTRY_W-1:0] e0_q, e0_d, e1_q, e1_d;
  always_comb begin
    cnt_p = cnt_q - {1'b0, pop};
    e0_d  = (push && cnt_p == 2'd0) ? din : (pop ? e1_q : e0_q);
    e1_d  = (push && cnt_p == 2'd1) ? din : e1_q;
    cnt_d = flush ? 2'd0 : cnt_p + {1'b0, push};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end
  assign full  = cnt_q == 2'(DEPTH);
  assign empty = cnt_q == 2'd0;
  assign head  = e0_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC, start/halt FSM, redirect and fault control feeding a 2-entry fetch buffer
module fetch_sequencer import fetch_pkg::*; #(
  parameter logic [WORD_W-1:0] RESET_PC  = '0,
  parameter logic [WORD_W-1:0] MEM_WORDS = 32'd256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] mem_pc,
  input  logic [WORD_W-1:0] mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic              fault,
  output logic              busy
);
  state_e state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic fault_q, fault_d;
  logic full, empty, deq, active, flush, try_fetch, flt, fetch;
  logic [ENTRY_W-1:0] head;
  assign active    = state_q == RUN || state_q == DRAIN;
  assign flush     = active && redirect;
  assign deq       = instr_valid && instr_ready;
  assign try_fetch = state_q == RUN && !redirect && !halt_req && (!full || deq);
  assign flt       = try_fetch && pc_q >= MEM_WORDS;
  assign fetch     = try_fetch && !flt;
  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch),
    .pop   (deq && !flush),
    .flush (flush),
    .din   ({pc_q, mem_data}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q || flt;
    if (!active && start) begin
      state_d = RUN;
      pc_d    = RESET_PC;
      fault_d = 1'b0;
    end else if (flush) pc_d = redirect_pc;
    else if (fetch) pc_d = pc_q + 1'b1;
    if (state_q == RUN && (halt_req || flt)) state_d = DRAIN;
    if (state_q == DRAIN && empty) state_d = HALT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end
  assign mem_pc      = pc_q;
  assign instr_valid = !empty;
  assign instr       = head[WORD_W-1:0];
  assign instr_pc    = head[ENTRY_W-1:WORD_W];
  assign fault       = fault_q;
  assign busy        = active;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table, directed corner cases and random run against a queue model
module tb_fetch_sequencer;
  localparam logic [31:0] MW = 32'd40;
  logic clk = 0, rst_n = 0, start = 0, halt_req = 0, redirect = 0, instr_ready = 0;
  logic [31:0] redirect_pc = 0, mem_pc, mem_data, instr, instr_pc;
  logic instr_valid, fault, busy;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] p);
    return (p * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign mem_data = word(mem_pc);
  fetch_sequencer #(.RESET_PC(32'd0), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_pc(mem_pc), .mem_data(mem_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .fault(fault), .busy(busy)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  typedef struct {
    logic s, h, r; logic [31:0] rpc; logic rd;
    logic e_busy, e_valid; logic [31:0] e_ipc, e_mpc;
  } vec_t;
  vec_t tbl[20];
  bit m_run, m_drain, m_fault;
  logic [31:0] m_pc;
  logic [63:0] mq[$];
  task automatic mstep(input logic s, input logic h, input logic r, input logic [31:0] rp, input logic rd);
    int n;
    bit run, drn, deq, flt;
    n = mq.size(); run = m_run; drn = m_drain; deq = n > 0 && rd; flt = 0;
    if (!run && !drn) begin
      if (s) begin m_run = 1; m_pc = 0; m_fault = 0; end
    end else if (r) begin
      mq.delete(); m_pc = rp;
    end else begin
      if (deq) void'(mq.pop_front());
      if (run && !h && (n < 2 || deq)) begin
        if (m_pc >= MW) begin flt = 1; m_fault = 1; end
        else begin mq.push_back({m_pc, word(m_pc)}); m_pc++; end
      end
    end
    if (run && (h || flt)) begin m_run = 0; m_drain = 1; end
    if (drn && n == 0) m_drain = 0;
  endtask
  task automatic mcheck();
    chk("rnd_valid", instr_valid, mq.size() > 0);
    chk("rnd_mem_pc", mem_pc, m_pc);
    chk("rnd_fault", fault, m_fault);
    chk("rnd_busy", busy, m_run || m_drain);
    if (mq.size() > 0) begin
      chk("rnd_instr_pc", instr_pc, mq[0][63:32]);
      chk("rnd_instr", instr, mq[0][31:0]);
    end
  endtask
  initial begin
    int nexp;
    tbl[0]  = '{1,0,0,0,1, 1,0,0,0};
    tbl[1]  = '{0,0,0,0,0, 1,1,0,1};
    tbl[2]  = '{0,0,0,0,0, 1,1,0,2};
    tbl[3]  = '{0,0,0,0,0, 1,1,0,2};
    tbl[4]  = '{0,0,0,0,0, 1,1,0,2};
    tbl[5]  = '{0,0,0,0,0, 1,1,0,2};
    tbl[6]  = '{0,0,0,0,0, 1,1,0,2};
    tbl[7]  = '{0,0,0,0,1, 1,1,1,3};
    tbl[8]  = '{0,0,0,0,1, 1,1,2,4};
    tbl[9]  = '{0,0,0,0,1, 1,1,3,5};
    tbl[10] = '{0,0,0,0,1, 1,1,4,6};
    tbl[11] = '{0,0,0,0,1, 1,1,5,7};
    tbl[12] = '{0,0,1,32'h20,1, 1,0,0,32'h20};
    tbl[13] = '{0,0,0,0,1, 1,1,32'h20,32'h21};
    tbl[14] = '{0,0,0,0,0, 1,1,32'h20,32'h22};
    tbl[15] = '{0,1,0,0,0, 1,1,32'h20,32'h22};
    tbl[16] = '{0,0,0,0,1, 1,1,32'h21,32'h22};
    tbl[17] = '{0,0,0,0,1, 1,0,0,32'h22};
    tbl[18] = '{0,0,0,0,1, 0,0,0,32'h22};
    tbl[19] = '{1,0,0,0,1, 1,0,0,0};
    repeat (2) @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_mem_pc", mem_pc, 0);
    chk("rst_fault", fault, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      start = tbl[i].s; halt_req = tbl[i].h; redirect = tbl[i].r;
      redirect_pc = tbl[i].rpc; instr_ready = tbl[i].rd;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_valid", i), instr_valid, tbl[i].e_valid);
      chk($sformatf("v%0d_mem_pc", i), mem_pc, tbl[i].e_mpc);
      chk($sformatf("v%0d_fault", i), fault, 0);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
        chk($sformatf("v%0d_instr", i), instr, word(tbl[i].e_ipc));
      end
    end
    start = 0; halt_req = 0; redirect = 0; instr_ready = 1;
    nexp = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (instr_valid) begin
        chk("flt_stream_pc", instr_pc, nexp);
        chk("flt_stream_instr", instr, word(nexp));
        nexp++;
      end
    end
    chk("flt_count", nexp, MW);
    chk("flt_fault", fault, 1);
    chk("flt_busy", busy, 0);
    chk("flt_mem_pc", mem_pc, MW);
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    chk("restart_fault", fault, 0);
    chk("restart_busy", busy, 1);
    chk("restart_mem_pc", mem_pc, 0);
    @(posedge clk);
    @(negedge clk);
    chk("restart_valid", instr_valid, 1);
    chk("restart_instr_pc", instr_pc, 0);
    instr_ready = 0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("pre_arst_valid", instr_valid, 1);
    chk("pre_arst_mem_pc", mem_pc, 2);
    rst_n = 0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_mem_pc", mem_pc, 0);
    chk("arst_busy", busy, 0);
    chk("arst_instr_pc", instr_pc, 0);
    @(negedge clk);
    rst_n = 1;
    m_run = 0; m_drain = 0; m_fault = 0; m_pc = 0; mq.delete();
    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(0, 7) == 0;
      halt_req = $urandom_range(0, 15) == 0;
      redirect = $urandom_range(0, 9) == 0;
      redirect_pc = $urandom_range(0, MW + 2);
      instr_ready = $urandom_range(0, 3) != 0;
      @(posedge clk);
      mstep(start, halt_req, redirect, redirect_pc, instr_ready);
      @(negedge clk);
      mcheck();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
